// File: rtl/eth_link_ctrl_pkg.sv
// Shared types for the 10G SFP+ link bring-up sequencer: state encoding and counter widths.
package eth_link_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 8;
    localparam int unsigned DROP_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        DISABLED   = 3'd0,
        HOLD_RESET = 3'd1,
        WAIT_TX    = 3'd2,
        WAIT_RX    = 3'd3,
        RX_RESET   = 3'd4,
        WAIT_LOCK  = 3'd5,
        LINK_UP    = 3'd6
    } link_state_e;

    // States in which losing a reference/QPLL lock forces a full re-sequence
    function automatic logic is_post_tx(input link_state_e s);
        return s inside {WAIT_RX, RX_RESET, WAIT_LOCK, LINK_UP};
    endfunction

endpackage

// File: rtl/eth_link_debounce.sv
// Good-run counter: o_stable_c flags the cycle that completes DEBOUNCE consecutive good cycles.
module eth_link_debounce
    import eth_link_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_good,
    input  logic i_clear,
    output logic o_stable_c
);

    localparam int unsigned RUN_W = $clog2(DEBOUNCE + 1);

    logic [RUN_W-1:0] r_run;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || !i_good) begin
            r_run <= '0;
        end else if (r_run != RUN_W'(DEBOUNCE)) begin
            r_run <= r_run + RUN_W'(1);
        end
    end

    // The current good cycle counts toward the run
    assign o_stable_c = i_good && !i_clear && (r_run == RUN_W'(DEBOUNCE - 1));

endmodule

// File: rtl/eth_10g_link_ctrl.sv
// Bring-up/recovery sequencer for one 10G SFP+ link (QPLL/TX/RX reset-done -> block lock).
// Optional: define ETH_LINK_CTRL_STATS_EN to add the o_link_drops saturating counter.
module eth_10g_link_ctrl
    import eth_link_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned HOLD_CYCLES    = 1000,
    parameter int unsigned TX_TIMEOUT     = 2**20,
    parameter int unsigned RX_TIMEOUT     = 2**20,
    parameter int unsigned LOCK_TIMEOUT   = 2**20,
    parameter int unsigned RX_PULSE       = 16,
    parameter int unsigned DEBOUNCE       = 256,
    parameter int unsigned MAX_RX_RETRIES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_pll_lock,
    input  logic               i_gt_powergood,
    input  logic               i_gt_qpll0_lock,
    input  logic               i_gt_tx_reset_done,
    input  logic               i_gt_rx_reset_done,
    input  logic               i_rx_block_lock,
    input  logic               i_rx_high_ber,
    output logic               o_gt_hold_reset,
    output logic               o_gt_rx_reset_datapath,
    output logic               o_link_up,
    output logic [STATE_W-1:0] o_state,
    output logic [RETRY_W-1:0] o_full_retries
`ifdef ETH_LINK_CTRL_STATS_EN
    ,
    output logic [DROP_W-1:0]  o_link_drops
`endif
);

    link_state_e        r_state;
    link_state_e        w_next;
    logic [CNT_W-1:0]   r_timer;
    logic [RETRY_W-1:0] r_rx_retry;
    logic [RETRY_W-1:0] r_full_retries;
    logic               w_good;
    logic               w_stable_c;
    logic               w_full_inc;
    logic               w_retry_inc;
    logic               w_timer_restart;
    logic               w_rx_escalate;

    assign w_good = i_rx_block_lock && !i_rx_high_ber;

    eth_link_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_good     (w_good),
        .i_clear    (r_state != WAIT_LOCK),
        .o_stable_c (w_stable_c)
    );

    // Next-state decode; within a state earlier checks win and success beats timeout
    always_comb begin
        w_next          = r_state;
        w_full_inc      = 1'b0;
        w_retry_inc     = 1'b0;
        w_timer_restart = 1'b0;
        w_rx_escalate   = 1'b0;
        if (!i_enable) begin
            w_next = DISABLED;
        end else if (is_post_tx(r_state) && !(i_pll_lock && i_gt_qpll0_lock)) begin
            w_next = HOLD_RESET;
        end else begin
            case (r_state)
                DISABLED: w_next = HOLD_RESET;
                HOLD_RESET: begin
                    if (r_timer == CNT_W'(HOLD_CYCLES - 1)) begin
                        if (i_pll_lock) w_next = WAIT_TX;
                        else            w_timer_restart = 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (i_gt_powergood && i_gt_qpll0_lock && i_gt_tx_reset_done) begin
                        w_next = WAIT_RX;
                    end else if (r_timer == CNT_W'(TX_TIMEOUT)) begin
                        w_next     = HOLD_RESET;
                        w_full_inc = 1'b1;
                    end
                end
                WAIT_RX: begin
                    if (i_gt_rx_reset_done)                  w_next = WAIT_LOCK;
                    else if (r_timer == CNT_W'(RX_TIMEOUT))  w_rx_escalate = 1'b1;
                end
                RX_RESET: begin
                    if (r_timer == CNT_W'(RX_PULSE - 1)) begin
                        w_next      = WAIT_RX;
                        w_retry_inc = 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (w_stable_c)                            w_next = LINK_UP;
                    else if (r_timer == CNT_W'(LOCK_TIMEOUT))  w_rx_escalate = 1'b1;
                    else if (!i_gt_rx_reset_done)              w_next = WAIT_RX;
                end
                LINK_UP: begin
                    if (!i_gt_tx_reset_done)      w_next = HOLD_RESET;
                    else if (!i_gt_rx_reset_done) w_next = WAIT_RX;
                    else if (!w_good)             w_next = WAIT_LOCK;
                end
                default: w_next = DISABLED;
            endcase
            // Too many datapath resets escalate to a full transceiver reset
            if (w_rx_escalate) begin
                if (r_rx_retry == RETRY_W'(MAX_RX_RETRIES)) begin
                    w_next     = HOLD_RESET;
                    w_full_inc = 1'b1;
                end else begin
                    w_next = RX_RESET;
                end
            end
        end
    end

    // State, counters and outputs decoded from the state being entered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state                <= DISABLED;
            r_timer                <= '0;
            r_rx_retry             <= '0;
            r_full_retries         <= '0;
            o_gt_hold_reset        <= 1'b1;
            o_gt_rx_reset_datapath <= 1'b0;
            o_link_up              <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || w_timer_restart) begin
                r_timer <= '0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + CNT_W'(1);
            end
            if (w_full_inc && (r_full_retries != '1)) begin
                r_full_retries <= r_full_retries + RETRY_W'(1);
            end
            if ((r_state == HOLD_RESET) || ((w_next == LINK_UP) && (r_state != LINK_UP))) begin
                r_rx_retry <= '0;
            end else if (w_retry_inc && (r_rx_retry != '1)) begin
                r_rx_retry <= r_rx_retry + RETRY_W'(1);
            end
            o_gt_hold_reset        <= (w_next == DISABLED) || (w_next == HOLD_RESET);
            o_gt_rx_reset_datapath <= (w_next == RX_RESET);
            o_link_up              <= (w_next == LINK_UP);
        end
    end

    assign o_state        = r_state;
    assign o_full_retries = r_full_retries;

`ifdef ETH_LINK_CTRL_STATS_EN
    logic [DROP_W-1:0] r_link_drops;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_link_drops <= '0;
        end else if ((r_state == LINK_UP) && (w_next != LINK_UP) && (r_link_drops != '1)) begin
            r_link_drops <= r_link_drops + DROP_W'(1);
        end
    end

    assign o_link_drops = r_link_drops;
`endif

endmodule

// File: tb/tb_eth_10g_link_ctrl.sv
// Directed bench for eth_10g_link_ctrl with short timers (hold 8, timeouts 64, pulse 4, debounce 4).
module tb_eth_10g_link_ctrl;
    import eth_link_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, enable, pll_lock, powergood, qpll_lock, tx_done, rx_done, block_lock, high_ber;
    logic       hold, rxrst, link_up;
    logic [2:0] state;
    logic [7:0] full_retries;
`ifdef ETH_LINK_CTRL_STATS_EN
    logic [15:0] link_drops;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    eth_10g_link_ctrl #(
        .CNT_W(24), .HOLD_CYCLES(8), .TX_TIMEOUT(64), .RX_TIMEOUT(64), .LOCK_TIMEOUT(64),
        .RX_PULSE(4), .DEBOUNCE(4), .MAX_RX_RETRIES(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_pll_lock(pll_lock),
        .i_gt_powergood(powergood), .i_gt_qpll0_lock(qpll_lock),
        .i_gt_tx_reset_done(tx_done), .i_gt_rx_reset_done(rx_done),
        .i_rx_block_lock(block_lock), .i_rx_high_ber(high_ber),
        .o_gt_hold_reset(hold), .o_gt_rx_reset_datapath(rxrst), .o_link_up(link_up),
        .o_state(state), .o_full_retries(full_retries)
`ifdef ETH_LINK_CTRL_STATS_EN
        , .o_link_drops(link_drops)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_good();
        pll_lock = 1'b1; powergood = 1'b1; qpll_lock = 1'b1; tx_done = 1'b1;
        rx_done = 1'b1; block_lock = 1'b1; high_ber = 1'b0;
    endtask

    task automatic do_reset();
        set_good();
        enable = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        ok = (state === st);
    endtask

    // Counts consecutive samples in st, including the current one
    task automatic count_in_state(input logic [2:0] st, output int n);
        n = 1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (state === st) n++;
            else break;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_tests++; if (hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold got=%b exp=1", hold); end
        n_tests++; if (rxrst !== 1'b0) begin n_fail++; $display("FAIL reset_rxrst got=%b exp=0", rxrst); end
        n_tests++; if (link_up !== 1'b0) begin n_fail++; $display("FAIL reset_link got=%b exp=0", link_up); end
        n_tests++; if (full_retries !== 8'd0) begin n_fail++; $display("FAIL reset_retries got=%0d exp=0", full_retries); end
        tick();
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL disabled_stay got=%0d exp=0", state); end
    endtask

    task automatic test_happy();
        int n;
        do_reset();
        enable = 1'b1;
        tick();
        n_tests++; if (state !== 3'd1 || hold !== 1'b1) begin n_fail++; $display("FAIL happy_hold_entry state=%0d hold=%b exp=1/1", state, hold); end
        count_in_state(3'd1, n);
        n_tests++; if (n != 8) begin n_fail++; $display("FAIL happy_hold_len got=%0d exp=8", n); end
        n_tests++; if (state !== 3'd2 || hold !== 1'b0) begin n_fail++; $display("FAIL happy_wait_tx state=%0d hold=%b exp=2/0", state, hold); end
        tick();
        n_tests++; if (state !== 3'd3) begin n_fail++; $display("FAIL happy_wait_rx got=%0d exp=3", state); end
        tick();
        n_tests++; if (state !== 3'd5) begin n_fail++; $display("FAIL happy_wait_lock got=%0d exp=5", state); end
        count_in_state(3'd5, n);
        n_tests++; if (n != 4) begin n_fail++; $display("FAIL happy_debounce_len got=%0d exp=4", n); end
        n_tests++; if (state !== 3'd6 || link_up !== 1'b1) begin n_fail++; $display("FAIL happy_link state=%0d link=%b exp=6/1", state, link_up); end
    endtask

    task automatic test_ber_glitch();
        int n;
        high_ber = 1'b1;
        tick();
        high_ber = 1'b0;
        n_tests++; if (state !== 3'd5 || link_up !== 1'b0) begin n_fail++; $display("FAIL ber_drop state=%0d link=%b exp=5/0", state, link_up); end
        count_in_state(3'd5, n);
        n_tests++; if (n != 4) begin n_fail++; $display("FAIL ber_relock_len got=%0d exp=4", n); end
        n_tests++; if (link_up !== 1'b1) begin n_fail++; $display("FAIL ber_relock_link got=%b exp=1", link_up); end
    endtask

    task automatic test_linkup_exits();
        bit ok;
        rx_done = 1'b0;
        tick();
        rx_done = 1'b1;
        n_tests++; if (state !== 3'd3 || link_up !== 1'b0) begin n_fail++; $display("FAIL rxdone_drop state=%0d link=%b exp=3/0", state, link_up); end
        wait_state(3'd6, 20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rxdone_relink state=%0d exp=6", state); end
        tx_done = 1'b0;
        tick();
        tx_done = 1'b1;
        n_tests++; if (state !== 3'd1 || hold !== 1'b1) begin n_fail++; $display("FAIL txdone_drop state=%0d hold=%b exp=1/1", state, hold); end
        wait_state(3'd6, 40, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL txdone_relink state=%0d exp=6", state); end
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        n_tests++; if (state !== 3'd1 || hold !== 1'b1 || link_up !== 1'b0) begin
            n_fail++; $display("FAIL pll_drop state=%0d hold=%b link=%b exp=1/1/0", state, hold, link_up); end
        n_tests++; if (full_retries !== 8'd0) begin n_fail++; $display("FAIL pll_drop_retries got=%0d exp=0", full_retries); end
    endtask

    task automatic test_hold_restart();
        bit ok;
        do_reset();
        pll_lock = 1'b0;
        enable = 1'b1;
        repeat (30) tick();
        n_tests++; if (state !== 3'd1 || hold !== 1'b1) begin n_fail++; $display("FAIL hold_nopll state=%0d hold=%b exp=1/1", state, hold); end
        pll_lock = 1'b1;
        wait_state(3'd2, 20, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL hold_pll_back state=%0d exp=2", state); end
    endtask

    task automatic test_tx_timeout();
        bit ok;
        int n;
        do_reset();
        tx_done = 1'b0;
        enable = 1'b1;
        for (int r = 1; r <= 2; r++) begin
            wait_state(3'd2, 20, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL tx_reach_wait_tx round=%0d state=%0d exp=2", r, state); end
            count_in_state(3'd2, n);
            n_tests++; if (n != 65) begin n_fail++; $display("FAIL tx_timeout_len round=%0d got=%0d exp=65", r, n); end
            n_tests++; if (state !== 3'd1 || hold !== 1'b1 || full_retries !== 8'(r)) begin
                n_fail++; $display("FAIL tx_timeout_retry state=%0d hold=%b retries=%0d exp=1/1/%0d", state, hold, full_retries, r); end
        end
    endtask

    task automatic test_rx_retry();
        bit ok;
        int pulses = 0;
        int high = 0;
        logic prev = 1'b0;
        do_reset();
        rx_done = 1'b0;
        enable = 1'b1;
        wait_state(3'd3, 30, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rx_reach_wait_rx state=%0d exp=3", state); end
        for (int i = 0; i < 1000 && state !== 3'd1; i++) begin
            tick();
            if (rxrst === 1'b1) high++;
            if (rxrst === 1'b1 && prev === 1'b0) pulses++;
            prev = rxrst;
        end
        n_tests++; if (pulses != 2 || high != 8) begin n_fail++; $display("FAIL rx_pulses got=%0d/%0d exp=2/8", pulses, high); end
        n_tests++; if (state !== 3'd1 || full_retries !== 8'd1) begin
            n_fail++; $display("FAIL rx_escalate state=%0d retries=%0d exp=1/1", state, full_retries); end
    endtask

    task automatic test_disable_mid_pulse();
        bit ok;
        do_reset();
        rx_done = 1'b0;
        enable = 1'b1;
        wait_state(3'd4, 200, ok);
        tick();
        n_tests++; if (!ok || rxrst !== 1'b1) begin n_fail++; $display("FAIL mid_pulse state=%0d rxrst=%b exp=4/1", state, rxrst); end
        enable = 1'b0;
        tick();
        n_tests++; if (state !== 3'd0 || rxrst !== 1'b0 || hold !== 1'b1) begin
            n_fail++; $display("FAIL abort_pulse state=%0d rxrst=%b hold=%b exp=0/0/1", state, rxrst, hold); end
    endtask

    task automatic test_stats();
`ifdef ETH_LINK_CTRL_STATS_EN
        bit ok;
        do_reset();
        n_tests++; if (link_drops !== 16'd0) begin n_fail++; $display("FAIL drops_reset got=%0d exp=0", link_drops); end
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_state(3'd6, 40, ok);
            high_ber = 1'b1;
            tick();
            high_ber = 1'b0;
        end
        wait_state(3'd6, 40, ok);
        enable = 1'b0;
        tick();
        n_tests++; if (link_drops !== 16'd3) begin n_fail++; $display("FAIL drops_count got=%0d exp=3", link_drops); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (link_drops !== 16'd0) begin n_fail++; $display("FAIL drops_cleared got=%0d exp=0", link_drops); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        set_good();
        test_reset();
        test_happy();
        test_ber_glitch();
        test_linkup_exits();
        test_hold_restart();
        test_tx_timeout();
        test_rx_retry();
        test_disable_mid_pulse();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
